ysyx_22050019_mem_arb: RTL

//  Arbitrates one shared memory port between the instruction fetch unit (IF, read-only) and the load/store path (LS, read/write).

---
 rtl/ysyx_22050019_mem_arb_pkg.sv | 21 ++
 rtl/ysyx_22050019_sat_cnt.sv | 33 +++
 rtl/ysyx_22050019_mem_arb.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ysyx_22050019_mem_arb_pkg.sv
// Shared types for the IF/LS memory arbiter: FSM state and owner encodings,
// plus a width helper for the fairness counters.
package ysyx_22050019_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ysyx_22050019_sat_cnt.sv
// Saturating up-counter with synchronous clear. Clear wins over increment.
// Used as the IF starvation counter; generic enough for other fairness counts.
module ysyx_22050019_sat_cnt #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         at_max_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;

  // Count up on inc, hold at MAX, return to zero on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = (cnt_q == MAX_V);

endmodule

// File: rtl/ysyx_22050019_mem_arb.sv
// Shared memory port arbiter between instruction fetch (read-only) and the
// load/store path. One transaction at a time: IDLE grants, REQ presents the
// registered request to memory, RESP waits for the response and routes it
// back to the owner. LS has priority; the starvation counter forces an IF win
// after MAX_WAIT consecutive losses.
//
// Handshake: a requester holds valid and its payload until it sees ready.
// ready is a one-cycle pulse, only ever driven in IDLE, and at most one
// requester sees it; the payload present in that cycle is the one served.
// rvalid is a one-cycle pulse to the owner in the cycle memory responds,
// with rdata passed straight through from mem_rdata.
module ysyx_22050019_mem_arb
  import ysyx_22050019_mem_arb_pkg::*;
#(
  parameter  int ADDR_W   = 64,
  parameter  int DATA_W   = 64,
  parameter  int MAX_WAIT = 4,
  localparam int MASK_W   = DATA_W / 8,
  localparam int CNT_W    = cnt_width(MAX_WAIT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_valid,
  input  logic              ls_wen,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [MASK_W-1:0] ls_wmask,
  output logic              ls_ready,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_err,
  output logic [1:0]        dbg_state,
  output logic [CNT_W-1:0]  dbg_starve_cnt
);

  arb_state_e        state_q;
  arb_owner_e        owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic              wen_q;
  logic              arb_err_q;

  logic              in_idle;
  logic              grant_ls;
  logic              grant_if;
  logic              starve_max;
  logic              resp_hit;
  logic [CNT_W-1:0]  starve_cnt;

  // Arbitration is only live in IDLE, and never while reset is held, so no
  // ready can leak out during an asynchronous reset.
  assign in_idle  = (state_q == ARB_IDLE) && !rst;
  assign grant_ls = in_idle && ls_valid && !(if_valid && starve_max);
  assign grant_if = in_idle && if_valid && !grant_ls;
  assign resp_hit = (state_q == ARB_RESP) && mem_resp_valid;

  // Counts LS wins that happened while IF was also waiting.
  ysyx_22050019_sat_cnt #(
    .MAX (MAX_WAIT),
    .W   (CNT_W)
  ) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (grant_ls && if_valid),
    .clr_i    (grant_if),
    .cnt_o    (starve_cnt),
    .at_max_o (starve_max)
  );

  // Arbiter FSM: latch winner payload in IDLE, hand it to memory in REQ,
  // wait for the response in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (grant_ls) begin
            owner_q <= OWN_LS;
            addr_q  <= ls_addr;
            wdata_q <= ls_wdata;
            wmask_q <= ls_wen ? ls_wmask : '0;
            wen_q   <= ls_wen;
            state_q <= ARB_REQ;
          end else if (grant_if) begin
            owner_q <= OWN_IF;
            addr_q  <= if_addr;
            wdata_q <= '0;
            wmask_q <= '0;
            wen_q   <= 1'b0;
            state_q <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (mem_req_ready) begin
            state_q <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (mem_resp_valid) begin
            state_q <= ARB_IDLE;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  // Sticky flag for a memory response arriving when none is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_err_q <= 1'b0;
    end else if (mem_resp_valid && (state_q != ARB_RESP)) begin
      arb_err_q <= 1'b1;
    end
  end

  assign if_ready       = grant_if;
  assign ls_ready       = grant_ls;
  assign if_rvalid      = resp_hit && (owner_q == OWN_IF);
  assign ls_rvalid      = resp_hit && (owner_q == OWN_LS);
  assign if_rdata       = if_rvalid ? mem_rdata : '0;
  assign ls_rdata       = ls_rvalid ? mem_rdata : '0;

  assign mem_req_valid  = (state_q == ARB_REQ);
  assign mem_wen        = wen_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign arb_err        = arb_err_q;

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_cnt;

endmodule
